// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
// - WE_* : write-enable encoding understood by the data memory (dm_wr_ctrl).
// - RD_* : read-control encoding understood by the data memory (dm_rd_ctrl).
// - arb_state_e : arbiter FSM states.
package dmem_arbiter_pkg;

    localparam logic [1:0] WE_NONE = 2'd0;
    localparam logic [1:0] WE_WORD = 2'd1;
    localparam logic [1:0] WE_HALF = 2'd2;
    localparam logic [1:0] WE_BYTE = 2'd3;

    localparam logic [2:0] RD_NONE = 3'd0;
    localparam logic [2:0] RD_LW   = 3'd1;
    localparam logic [2:0] RD_LHU  = 3'd2;
    localparam logic [2:0] RD_LH   = 3'd3;
    localparam logic [2:0] RD_LBU  = 3'd4;
    localparam logic [2:0] RD_LB   = 3'd5;

    typedef enum logic [0:0] {
        ARB      = 1'b0,
        DBG_LOCK = 1'b1
    } arb_state_e;

    // A granted access with no write enable is a read and returns data.
    function automatic logic is_read(input logic [1:0] we);
        return (we == WE_NONE);
    endfunction

endpackage

// File: rtl/arb_req_mux.sv
// Steers the granted requester's access fields onto the memory port.
// Ports:
//   cpu_sel / dbg_sel          one-hot grant (both low = idle port)
//   cpu_* / dbg_*              addr, wdata, we, rd_ctrl of each requester
//   mem_a/mem_d/mem_we/mem_rd_ctrl  memory-side access fields, all zero when idle
module arb_req_mux
    import dmem_arbiter_pkg::*;
#(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic          cpu_sel,
    input  logic [1:0]    cpu_we,
    input  logic [2:0]    cpu_rd_ctrl,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          dbg_sel,
    input  logic [1:0]    dbg_we,
    input  logic [2:0]    dbg_rd_ctrl,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_d,
    output logic [1:0]    mem_we,
    output logic [2:0]    mem_rd_ctrl
);

    // Select the granted requester; an idle port drives all zeros.
    always_comb begin
        mem_a       = {AW{1'b0}};
        mem_d       = {DW{1'b0}};
        mem_we      = WE_NONE;
        mem_rd_ctrl = RD_NONE;
        if (cpu_sel) begin
            mem_a       = cpu_addr;
            mem_d       = cpu_wdata;
            mem_we      = cpu_we;
            mem_rd_ctrl = cpu_rd_ctrl;
        end else if (dbg_sel) begin
            mem_a       = dbg_addr;
            mem_d       = dbg_wdata;
            mem_we      = dbg_we;
            mem_rd_ctrl = dbg_rd_ctrl;
        end else begin
            mem_a       = {AW{1'b0}};
            mem_d       = {DW{1'b0}};
            mem_we      = WE_NONE;
            mem_rd_ctrl = RD_NONE;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single data-memory port between the CPU MEM stage and the debug unit.
// The CPU has priority; debug gets a forced grant after STARVE_MAX waiting cycles
// and may lock the port for bursts of at most LOCK_MAX cycles.
// Ports:
//   clk, rst                       clock, async active-high reset
//   cpu_* / dbg_* (req,we,rd_ctrl,addr,wdata)  access requests
//   dbg_lock                       keep ownership across consecutive debug accesses
//   cpu_gnt/dbg_gnt                access performed this cycle (combinational)
//   cpu_stall                      cpu_req & ~cpu_gnt
//   cpu_rdata/dbg_rdata, *_rvalid  registered read data, valid for one cycle
//   lock_abort                     pulse in the last cycle of a forcibly ended lock
//   mem_a/mem_d/mem_we/mem_rd_ctrl/mem_spo   memory port
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int AW         = 10,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4,
    parameter int LOCK_MAX   = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic [1:0]    cpu_we,
    input  logic [2:0]    cpu_rd_ctrl,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_stall,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_rvalid,
    input  logic          dbg_req,
    input  logic [1:0]    dbg_we,
    input  logic [2:0]    dbg_rd_ctrl,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    input  logic          dbg_lock,
    output logic          dbg_gnt,
    output logic [DW-1:0] dbg_rdata,
    output logic          dbg_rvalid,
    output logic          lock_abort,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_d,
    output logic [1:0]    mem_we,
    output logic [2:0]    mem_rd_ctrl,
    input  logic [DW-1:0] mem_spo
);

    localparam int STARVE_W = $clog2(STARVE_MAX + 1);
    localparam int LOCK_W   = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
    localparam logic [STARVE_W-1:0] STARVE_TOP = STARVE_W'(STARVE_MAX);
    localparam logic [LOCK_W-1:0]   LOCK_LAST  = LOCK_W'(LOCK_MAX - 1);

    arb_state_e          state_r;
    arb_state_e          state_nxt_s;
    logic [STARVE_W-1:0] starve_cnt_r;
    logic [LOCK_W-1:0]   lock_cnt_r;
    logic                relock_block_r;
    logic                arb_cpu_s;
    logic                arb_dbg_s;
    logic                cpu_gnt_s;
    logic                dbg_gnt_s;
    logic                lock_abort_s;
    logic [DW-1:0]       cpu_rdata_r;
    logic                cpu_rvalid_r;
    logic [DW-1:0]       dbg_rdata_r;
    logic                dbg_rvalid_r;

    // Open arbitration: CPU first unless debug has waited STARVE_MAX cycles.
    always_comb begin
        arb_cpu_s = 1'b0;
        arb_dbg_s = 1'b0;
        if (cpu_req && dbg_req) begin
            if (starve_cnt_r == STARVE_TOP) begin
                arb_dbg_s = 1'b1;
            end else begin
                arb_cpu_s = 1'b1;
            end
        end else begin
            arb_cpu_s = cpu_req;
            arb_dbg_s = dbg_req;
        end
    end

    // Grant decode and next state; reset forces an idle port immediately.
    always_comb begin
        cpu_gnt_s    = 1'b0;
        dbg_gnt_s    = 1'b0;
        lock_abort_s = 1'b0;
        state_nxt_s  = state_r;
        if (rst) begin
            state_nxt_s = ARB;
        end else begin
            case (state_r)
                ARB: begin
                    cpu_gnt_s = arb_cpu_s;
                    dbg_gnt_s = arb_dbg_s;
                    // After a forced release the lock stays closed until dbg_lock drops.
                    if (arb_dbg_s && dbg_lock && !relock_block_r) begin
                        state_nxt_s = DBG_LOCK;
                    end else begin
                        state_nxt_s = ARB;
                    end
                end
                DBG_LOCK: begin
                    if (dbg_lock) begin
                        dbg_gnt_s = dbg_req;
                        if (lock_cnt_r == LOCK_LAST) begin
                            lock_abort_s = 1'b1;
                            state_nxt_s  = ARB;
                        end else begin
                            state_nxt_s  = DBG_LOCK;
                        end
                    end else begin
                        // Lock released voluntarily: this cycle is already open arbitration.
                        cpu_gnt_s   = arb_cpu_s;
                        dbg_gnt_s   = arb_dbg_s;
                        state_nxt_s = ARB;
                    end
                end
                default: begin
                    state_nxt_s = ARB;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ARB;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Lock duration counter, running only while the lock persists.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_cnt_r <= {LOCK_W{1'b0}};
        end else if ((state_r == DBG_LOCK) && (state_nxt_s == DBG_LOCK)) begin
            lock_cnt_r <= lock_cnt_r + LOCK_W'(1);
        end else begin
            lock_cnt_r <= {LOCK_W{1'b0}};
        end
    end

    // Debug starvation counter, saturating at STARVE_MAX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_r <= {STARVE_W{1'b0}};
        end else if (dbg_req && !dbg_gnt_s) begin
            if (starve_cnt_r != STARVE_TOP) begin
                starve_cnt_r <= starve_cnt_r + STARVE_W'(1);
            end else begin
                starve_cnt_r <= starve_cnt_r;
            end
        end else begin
            starve_cnt_r <= {STARVE_W{1'b0}};
        end
    end

    // Re-lock inhibit: set by a forced release, cleared once dbg_lock is seen low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            relock_block_r <= 1'b0;
        end else if (lock_abort_s) begin
            relock_block_r <= 1'b1;
        end else if (!dbg_lock) begin
            relock_block_r <= 1'b0;
        end else begin
            relock_block_r <= relock_block_r;
        end
    end

    // CPU read capture; rvalid pulses for the cycle after a granted read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_rdata_r  <= {DW{1'b0}};
            cpu_rvalid_r <= 1'b0;
        end else if (cpu_gnt_s && is_read(cpu_we)) begin
            cpu_rdata_r  <= mem_spo;
            cpu_rvalid_r <= 1'b1;
        end else begin
            cpu_rdata_r  <= cpu_rdata_r;
            cpu_rvalid_r <= 1'b0;
        end
    end

    // Debug read capture; rvalid pulses for the cycle after a granted read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbg_rdata_r  <= {DW{1'b0}};
            dbg_rvalid_r <= 1'b0;
        end else if (dbg_gnt_s && is_read(dbg_we)) begin
            dbg_rdata_r  <= mem_spo;
            dbg_rvalid_r <= 1'b1;
        end else begin
            dbg_rdata_r  <= dbg_rdata_r;
            dbg_rvalid_r <= 1'b0;
        end
    end

    arb_req_mux #(
        .AW (AW),
        .DW (DW)
    ) u_req_mux (
        .cpu_sel     (cpu_gnt_s),
        .cpu_we      (cpu_we),
        .cpu_rd_ctrl (cpu_rd_ctrl),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .dbg_sel     (dbg_gnt_s),
        .dbg_we      (dbg_we),
        .dbg_rd_ctrl (dbg_rd_ctrl),
        .dbg_addr    (dbg_addr),
        .dbg_wdata   (dbg_wdata),
        .mem_a       (mem_a),
        .mem_d       (mem_d),
        .mem_we      (mem_we),
        .mem_rd_ctrl (mem_rd_ctrl)
    );

    assign cpu_gnt    = cpu_gnt_s;
    assign dbg_gnt    = dbg_gnt_s;
    assign cpu_stall  = cpu_req & ~cpu_gnt_s & ~rst;
    assign lock_abort = lock_abort_s;
    assign cpu_rdata  = cpu_rdata_r;
    assign cpu_rvalid = cpu_rvalid_r;
    assign dbg_rdata  = dbg_rdata_r;
    assign dbg_rvalid = dbg_rvalid_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small byte-addressed data memory model.
module tb_dmem_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, dbg_req, dbg_lock;
    logic [1:0]    cpu_we, dbg_we;
    logic [2:0]    cpu_rd_ctrl, dbg_rd_ctrl;
    logic [AW-1:0] cpu_addr, dbg_addr;
    logic [DW-1:0] cpu_wdata, dbg_wdata;
    logic          cpu_gnt, cpu_stall, cpu_rvalid, dbg_gnt, dbg_rvalid, lock_abort;
    logic [DW-1:0] cpu_rdata, dbg_rdata;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_d, mem_spo;
    logic [1:0]    mem_we;
    logic [2:0]    mem_rd_ctrl;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(4), .LOCK_MAX(64)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_rd_ctrl(cpu_rd_ctrl),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_rd_ctrl(dbg_rd_ctrl),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_lock(dbg_lock),
        .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
        .lock_abort(lock_abort),
        .mem_a(mem_a), .mem_d(mem_d), .mem_we(mem_we), .mem_rd_ctrl(mem_rd_ctrl),
        .mem_spo(mem_spo)
    );

    // Data memory model: little-endian bytes, combinational read, write on posedge.
    logic [7:0]    mem_q [0:(1<<AW)-1];
    logic [AW-1:0] a1_s, a2_s, a3_s;
    assign a1_s = mem_a + 10'd1;
    assign a2_s = mem_a + 10'd2;
    assign a3_s = mem_a + 10'd3;

    always_comb begin
        case (mem_rd_ctrl)
            3'd1:    mem_spo = {mem_q[a3_s], mem_q[a2_s], mem_q[a1_s], mem_q[mem_a]};
            3'd2:    mem_spo = {16'h0000, mem_q[a1_s], mem_q[mem_a]};
            3'd3:    mem_spo = {{16{mem_q[a1_s][7]}}, mem_q[a1_s], mem_q[mem_a]};
            3'd4:    mem_spo = {24'h000000, mem_q[mem_a]};
            3'd5:    mem_spo = {{24{mem_q[mem_a][7]}}, mem_q[mem_a]};
            default: mem_spo = 32'h0000_0000;
        endcase
    end

    always @(posedge clk) begin
        case (mem_we)
            2'd1: begin
                mem_q[mem_a] <= mem_d[7:0];   mem_q[a1_s] <= mem_d[15:8];
                mem_q[a2_s]  <= mem_d[23:16]; mem_q[a3_s] <= mem_d[31:24];
            end
            2'd2: begin
                mem_q[mem_a] <= mem_d[7:0];   mem_q[a1_s] <= mem_d[15:8];
            end
            2'd3:    mem_q[mem_a] <= mem_d[7:0];
            default: ;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cpu(input logic req, input logic [1:0] we, input logic [2:0] rd,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        cpu_req = req; cpu_we = we; cpu_rd_ctrl = rd; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic set_dbg(input logic req, input logic lock, input logic [1:0] we,
                           input logic [2:0] rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
        dbg_req = req; dbg_lock = lock; dbg_we = we; dbg_rd_ctrl = rd; dbg_addr = a; dbg_wdata = d;
    endtask

    task automatic idle();
        set_cpu(1'b0, 2'd0, 3'd0, 10'h000, 32'h0);
        set_dbg(1'b0, 1'b0, 2'd0, 3'd0, 10'h000, 32'h0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        tick(); tick();
        cpu_req = 1'b1; dbg_req = 1'b1; cpu_rd_ctrl = 3'd1;
        #1;
        total++; if (cpu_gnt !== 1'b0)    begin bad++; $display("FAIL rst_cpu_gnt got=%0h want=0", cpu_gnt); end
        total++; if (dbg_gnt !== 1'b0)    begin bad++; $display("FAIL rst_dbg_gnt got=%0h want=0", dbg_gnt); end
        total++; if (cpu_stall !== 1'b0)  begin bad++; $display("FAIL rst_cpu_stall got=%0h want=0", cpu_stall); end
        total++; if (cpu_rvalid !== 1'b0) begin bad++; $display("FAIL rst_cpu_rvalid got=%0h want=0", cpu_rvalid); end
        total++; if (dbg_rvalid !== 1'b0) begin bad++; $display("FAIL rst_dbg_rvalid got=%0h want=0", dbg_rvalid); end
        total++; if (cpu_rdata !== 32'h0) begin bad++; $display("FAIL rst_cpu_rdata got=%0h want=0", cpu_rdata); end
        total++; if (dbg_rdata !== 32'h0) begin bad++; $display("FAIL rst_dbg_rdata got=%0h want=0", dbg_rdata); end
        total++; if (lock_abort !== 1'b0) begin bad++; $display("FAIL rst_lock_abort got=%0h want=0", lock_abort); end
        total++; if (mem_rd_ctrl !== 3'd0) begin bad++; $display("FAIL rst_mem_rd_ctrl got=%0h want=0", mem_rd_ctrl); end
        idle();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_cpu_read();
        tick();
        set_dbg(1'b1, 1'b0, 2'd1, 3'd0, 10'h010, 32'hDEADBEEF);
        #1;
        total++; if (dbg_gnt !== 1'b1)      begin bad++; $display("FAIL wr_dbg_gnt got=%0h want=1", dbg_gnt); end
        total++; if (mem_we !== 2'd1)       begin bad++; $display("FAIL wr_mem_we got=%0h want=1", mem_we); end
        total++; if (mem_a !== 10'h010)     begin bad++; $display("FAIL wr_mem_a got=%0h want=010", mem_a); end
        total++; if (mem_d !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_mem_d got=%0h want=deadbeef", mem_d); end
        tick();
        total++; if (dbg_rvalid !== 1'b0)   begin bad++; $display("FAIL wr_no_rvalid got=%0h want=0", dbg_rvalid); end
        set_cpu(1'b1, 2'd0, 3'd1, 10'h010, 32'h0);
        set_dbg(1'b1, 1'b0, 2'd0, 3'd1, 10'h010, 32'h0);
        #1;
        total++; if (cpu_gnt !== 1'b1)      begin bad++; $display("FAIL rd_cpu_gnt got=%0h want=1", cpu_gnt); end
        total++; if (dbg_gnt !== 1'b0)      begin bad++; $display("FAIL rd_dbg_gnt got=%0h want=0", dbg_gnt); end
        total++; if (mem_rd_ctrl !== 3'd1)  begin bad++; $display("FAIL rd_mem_rd_ctrl got=%0h want=1", mem_rd_ctrl); end
        total++; if (mem_we !== 2'd0)       begin bad++; $display("FAIL rd_mem_we got=%0h want=0", mem_we); end
        tick();
        total++; if (cpu_rvalid !== 1'b1)   begin bad++; $display("FAIL rd_cpu_rvalid got=%0h want=1", cpu_rvalid); end
        total++; if (cpu_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_cpu_rdata got=%0h want=deadbeef", cpu_rdata); end
        set_cpu(1'b0, 2'd0, 3'd0, 10'h000, 32'h0);
        #1;
        total++; if (dbg_gnt !== 1'b1)      begin bad++; $display("FAIL rd_dbg_alone got=%0h want=1", dbg_gnt); end
        tick();
        total++; if (cpu_rvalid !== 1'b0)   begin bad++; $display("FAIL rd_cpu_pulse got=%0h want=0", cpu_rvalid); end
        total++; if (dbg_rvalid !== 1'b1)   begin bad++; $display("FAIL rd_dbg_rvalid got=%0h want=1", dbg_rvalid); end
        total++; if (dbg_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_dbg_rdata got=%0h want=deadbeef", dbg_rdata); end
        idle();
    endtask

    task automatic test_starve();
        tick();
        set_cpu(1'b1, 2'd0, 3'd1, 10'h010, 32'h0);
        set_dbg(1'b1, 1'b0, 2'd0, 3'd1, 10'h010, 32'h0);
        for (int i = 1; i <= 8; i++) begin
            #1;
            total++; if (dbg_gnt !== (i == 5))   begin bad++; $display("FAIL starve_dbg_gnt cyc=%0d got=%0h want=%0h", i, dbg_gnt, (i == 5)); end
            total++; if (cpu_gnt !== (i != 5))   begin bad++; $display("FAIL starve_cpu_gnt cyc=%0d got=%0h want=%0h", i, cpu_gnt, (i != 5)); end
            total++; if (cpu_stall !== (i == 5)) begin bad++; $display("FAIL starve_cpu_stall cyc=%0d got=%0h want=%0h", i, cpu_stall, (i == 5)); end
            tick();
        end
        idle();
    endtask

    task automatic test_lock_burst();
        tick();
        set_dbg(1'b1, 1'b1, 2'd1, 3'd0, 10'h000, 32'h11111111);
        #1;
        total++; if (dbg_gnt !== 1'b1) begin bad++; $display("FAIL burst1_dbg_gnt got=%0h want=1", dbg_gnt); end
        tick();
        set_cpu(1'b1, 2'd0, 3'd1, 10'h004, 32'h0);
        set_dbg(1'b1, 1'b1, 2'd1, 3'd0, 10'h004, 32'h22222222);
        #1;
        total++; if (cpu_gnt !== 1'b0)   begin bad++; $display("FAIL burst2_cpu_gnt got=%0h want=0", cpu_gnt); end
        total++; if (cpu_stall !== 1'b1) begin bad++; $display("FAIL burst2_cpu_stall got=%0h want=1", cpu_stall); end
        total++; if (mem_a !== 10'h004)  begin bad++; $display("FAIL burst2_mem_a got=%0h want=004", mem_a); end
        tick();
        set_dbg(1'b1, 1'b1, 2'd1, 3'd0, 10'h008, 32'h33333333);
        #1;
        total++; if (cpu_gnt !== 1'b0)   begin bad++; $display("FAIL burst3_cpu_gnt got=%0h want=0", cpu_gnt); end
        total++; if (mem_d !== 32'h33333333) begin bad++; $display("FAIL burst3_mem_d got=%0h want=33333333", mem_d); end
        tick();
        set_dbg(1'b0, 1'b0, 2'd0, 3'd0, 10'h000, 32'h0);
        #1;
        total++; if (cpu_gnt !== 1'b1)   begin bad++; $display("FAIL burst_end_cpu_gnt got=%0h want=1", cpu_gnt); end
        tick();
        total++; if (cpu_rdata !== 32'h22222222) begin bad++; $display("FAIL burst_rdback got=%0h want=22222222", cpu_rdata); end
        idle();
    endtask

    task automatic test_lock_abort();
        tick();
        set_dbg(1'b1, 1'b1, 2'd0, 3'd1, 10'h000, 32'h0);
        #1;
        total++; if (dbg_gnt !== 1'b1) begin bad++; $display("FAIL abort_entry got=%0h want=1", dbg_gnt); end
        tick();
        set_cpu(1'b1, 2'd0, 3'd1, 10'h010, 32'h0);
        for (int n = 1; n <= 64; n++) begin
            #1;
            total++; if (lock_abort !== (n == 64)) begin bad++; $display("FAIL abort_pulse cyc=%0d got=%0h want=%0h", n, lock_abort, (n == 64)); end
            total++; if (cpu_gnt !== 1'b0)         begin bad++; $display("FAIL abort_locked cyc=%0d got=%0h want=0", n, cpu_gnt); end
            tick();
        end
        #1;
        total++; if (cpu_gnt !== 1'b1)    begin bad++; $display("FAIL abort_cpu_next got=%0h want=1", cpu_gnt); end
        total++; if (lock_abort !== 1'b0) begin bad++; $display("FAIL abort_one_pulse got=%0h want=0", lock_abort); end
        tick();
        cpu_req = 1'b0;
        #1;
        total++; if (dbg_gnt !== 1'b1)    begin bad++; $display("FAIL abort_dbg_open got=%0h want=1", dbg_gnt); end
        tick();
        cpu_req = 1'b1;
        #1;
        total++; if (cpu_gnt !== 1'b1)    begin bad++; $display("FAIL abort_no_relock got=%0h want=1", cpu_gnt); end
        tick();
        cpu_req = 1'b0; dbg_lock = 1'b0;
        #1;
        total++; if (dbg_gnt !== 1'b1)    begin bad++; $display("FAIL abort_unlock_gnt got=%0h want=1", dbg_gnt); end
        tick();
        dbg_lock = 1'b1;
        #1;
        total++; if (dbg_gnt !== 1'b1)    begin bad++; $display("FAIL relock_entry got=%0h want=1", dbg_gnt); end
        tick();
        cpu_req = 1'b1;
        #1;
        total++; if (cpu_gnt !== 1'b0)    begin bad++; $display("FAIL relock_holds got=%0h want=0", cpu_gnt); end
        tick();
        idle();
    endtask

    task automatic test_byte();
        tick();
        set_cpu(1'b1, 2'd3, 3'd0, 10'h003, 32'h000000AB);
        #1;
        total++; if (mem_we !== 2'd3) begin bad++; $display("FAIL sb_mem_we got=%0h want=3", mem_we); end
        tick();
        set_cpu(1'b0, 2'd0, 3'd0, 10'h000, 32'h0);
        set_dbg(1'b1, 1'b0, 2'd0, 3'd4, 10'h003, 32'h0);
        tick();
        total++; if (dbg_rdata !== 32'h000000AB) begin bad++; $display("FAIL lbu_rdata got=%0h want=000000ab", dbg_rdata); end
        dbg_rd_ctrl = 3'd5;
        tick();
        total++; if (dbg_rdata !== 32'hFFFFFFAB) begin bad++; $display("FAIL lb_rdata got=%0h want=ffffffab", dbg_rdata); end
        idle();
    endtask

    task automatic test_reset_mid();
        tick();
        set_dbg(1'b1, 1'b1, 2'd0, 3'd4, 10'h003, 32'h0);
        #1;
        total++; if (dbg_gnt !== 1'b1) begin bad++; $display("FAIL mid_dbg_gnt got=%0h want=1", dbg_gnt); end
        tick();
        set_cpu(1'b1, 2'd0, 3'd1, 10'h010, 32'h0);
        #1;
        total++; if (cpu_gnt !== 1'b0) begin bad++; $display("FAIL mid_locked got=%0h want=0", cpu_gnt); end
        rst = 1'b1;
        #1;
        total++; if (dbg_gnt !== 1'b0)     begin bad++; $display("FAIL mid_rst_dbg_gnt got=%0h want=0", dbg_gnt); end
        total++; if (mem_rd_ctrl !== 3'd0) begin bad++; $display("FAIL mid_rst_rd_ctrl got=%0h want=0", mem_rd_ctrl); end
        total++; if (mem_a !== 10'h000)    begin bad++; $display("FAIL mid_rst_mem_a got=%0h want=0", mem_a); end
        total++; if (dbg_rvalid !== 1'b0)  begin bad++; $display("FAIL mid_rst_rvalid got=%0h want=0", dbg_rvalid); end
        total++; if (dbg_rdata !== 32'h0)  begin bad++; $display("FAIL mid_rst_rdata got=%0h want=0", dbg_rdata); end
        tick();
        total++; if (dbg_rvalid !== 1'b0)  begin bad++; $display("FAIL mid_rst_dropped got=%0h want=0", dbg_rvalid); end
        rst = 1'b0;
        #1;
        total++; if (cpu_gnt !== 1'b1) begin bad++; $display("FAIL post_rst_arb got=%0h want=1", cpu_gnt); end
        tick();
        idle();
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_starve();
        test_lock_burst();
        test_lock_abort();
        test_byte();
        test_reset_mid();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
